// File: rtl/jump_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// jump_redirect_ctrl
//
// Decode-side jump controller. It consumes the registered JAL/JALR flags from
// the IF/ID jump register, computes the jump target and the link value, and
// issues a PC redirect to fetch through a valid/ready handshake. It also
// drives the IF/ID flush and the fetch stall for the bubble window. A target
// with bit 1 set raises a one-cycle misalignment exception and no redirect
// is issued. Every output is registered.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   jal_id          JAL flag from the IF/ID jump register
//   jalr_id         JALR flag from the IF/ID jump register (wins over JAL)
//   pc_id           PC of the decode-stage instruction
//   imm_id          sign-extended immediate
//   rs1_data_id     rs1 operand
//   rs1_ready       rs1 operand valid (no outstanding hazard)
//   redirect_valid  redirect request to fetch
//   redirect_pc     jump target, held stable until the handshake
//   redirect_ready  fetch accepts the redirect
//   flush_ir        synchronous clear for the IF/ID registers
//   stall_if        freeze the fetch PC
//   link_we         one-cycle register-file write strobe for rd
//   link_data       pc_id + 4
//   misalign_exc    one-cycle target-misaligned exception pulse
// ---------------------------------------------------------------------------
module jump_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jal_id,
  input  logic            jalr_id,
  input  logic [XLEN-1:0] pc_id,
  input  logic [XLEN-1:0] imm_id,
  input  logic [XLEN-1:0] rs1_data_id,
  input  logic            rs1_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush_ir,
  output logic            stall_if,
  output logic            link_we,
  output logic [XLEN-1:0] link_data,
  output logic            misalign_exc
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RS1,
    REDIRECT,
    FLUSH
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [XLEN-1:0] held_imm, held_imm_nxt;

  logic            valid_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            flush_nxt;
  logic            stall_nxt;
  logic            link_we_nxt;
  logic [XLEN-1:0] link_nxt;
  logic            exc_nxt;

  logic [XLEN-1:0] tgt;
  logic            take;

  // Next-state and next-output logic. The state-specific branches only say
  // whether a target was produced this cycle ("take"); the common target
  // check afterwards decides between a redirect and a misalignment exception,
  // so the IDLE and WAIT_RS1 paths behave identically once rs1 is known.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    held_imm_nxt = held_imm;
    valid_nxt    = 1'b0;
    pc_nxt       = redirect_pc;
    flush_nxt    = 1'b0;
    stall_nxt    = 1'b0;
    link_we_nxt  = 1'b0;
    link_nxt     = link_data;
    exc_nxt      = 1'b0;
    tgt          = '0;
    take         = 1'b0;

    case (state)
      IDLE: begin
        if (jalr_id) begin
          link_nxt = pc_id + XLEN'(4);
          if (rs1_ready) begin
            tgt  = rs1_data_id + imm_id;
            take = 1'b1;
          end else begin
            // Hold the immediate; the decode stage is frozen while we wait.
            held_imm_nxt = imm_id;
            stall_nxt    = 1'b1;
            state_nxt    = WAIT_RS1;
          end
        end else if (jal_id) begin
          link_nxt = pc_id + XLEN'(4);
          tgt      = pc_id + imm_id;
          take     = 1'b1;
        end
      end

      WAIT_RS1: begin
        stall_nxt = 1'b1;
        if (rs1_ready) begin
          tgt  = rs1_data_id + held_imm;
          take = 1'b1;
        end
      end

      REDIRECT: begin
        valid_nxt = 1'b1;
        stall_nxt = 1'b1;
        flush_nxt = 1'b1;
        if (redirect_valid && redirect_ready) begin
          valid_nxt = 1'b0;
          stall_nxt = 1'b0;
          if (FLUSH_CYCLES == 1) begin
            flush_nxt = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = 4'(FLUSH_CYCLES - 1);
            state_nxt = FLUSH;
          end
        end
      end

      FLUSH: begin
        // Jump flags seen here belong to instructions being flushed.
        cnt_nxt   = cnt - 4'd1;
        flush_nxt = 1'b1;
        if (cnt_nxt == 4'd0) begin
          flush_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (take) begin
      tgt[0] = 1'b0;
      pc_nxt = tgt;
      if (tgt[1]) begin
        exc_nxt   = 1'b1;
        flush_nxt = 1'b1;
        stall_nxt = 1'b0;
        state_nxt = IDLE;
      end else begin
        link_we_nxt = 1'b1;
        valid_nxt   = 1'b1;
        stall_nxt   = 1'b1;
        flush_nxt   = 1'b1;
        state_nxt   = REDIRECT;
      end
    end
  end

  // State, counter, held immediate and all registered outputs. Reset drops
  // any pending redirect and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      held_imm       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_ir       <= 1'b0;
      stall_if       <= 1'b0;
      link_we        <= 1'b0;
      link_data      <= '0;
      misalign_exc   <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      held_imm       <= held_imm_nxt;
      redirect_valid <= valid_nxt;
      redirect_pc    <= pc_nxt;
      flush_ir       <= flush_nxt;
      stall_if       <= stall_nxt;
      link_we        <= link_we_nxt;
      link_data      <= link_nxt;
      misalign_exc   <= exc_nxt;
    end
  end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jump_redirect_ctrl
//
// Self-checking bench for jump_redirect_ctrl with the default parameters
// (XLEN=32, FLUSH_CYCLES=2). A table of directed vectors is applied one per
// clock. Each row holds the inputs and the registered outputs expected just
// after that clock edge. A hand-written sequence covers asynchronous reset
// in the middle of a redirect.
// ---------------------------------------------------------------------------
module tb_jump_redirect_ctrl;

  localparam int XLEN = 32;
  localparam int NVEC = 25;

  logic            clk;
  logic            rst_n;
  logic            jal_id;
  logic            jalr_id;
  logic [XLEN-1:0] pc_id;
  logic [XLEN-1:0] imm_id;
  logic [XLEN-1:0] rs1_data_id;
  logic            rs1_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush_ir;
  logic            stall_if;
  logic            link_we;
  logic [XLEN-1:0] link_data;
  logic            misalign_exc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        jal;
    logic        jalr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        rs1_rdy;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_stall;
    logic        e_lwe;
    logic [31:0] e_link;
    logic        e_exc;
  } vec_t;

  vec_t vecs [NVEC];

  jump_redirect_ctrl #(
    .XLEN(XLEN),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .jal_id(jal_id),
    .jalr_id(jalr_id),
    .pc_id(pc_id),
    .imm_id(imm_id),
    .rs1_data_id(rs1_data_id),
    .rs1_ready(rs1_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .flush_ir(flush_ir),
    .stall_if(stall_if),
    .link_we(link_we),
    .link_data(link_data),
    .misalign_exc(misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(
    input logic jal, input logic jalr, input logic [31:0] pc,
    input logic [31:0] imm, input logic [31:0] rs1, input logic rs1_rdy,
    input logic rdy, input logic e_valid, input logic [31:0] e_pc,
    input logic e_flush, input logic e_stall, input logic e_lwe,
    input logic [31:0] e_link, input logic e_exc);
    vec_t v;
    v.jal = jal;         v.jalr = jalr;       v.pc = pc;
    v.imm = imm;         v.rs1 = rs1;         v.rs1_rdy = rs1_rdy;
    v.rdy = rdy;         v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_flush = e_flush; v.e_stall = e_stall; v.e_lwe = e_lwe;
    v.e_link = e_link;   v.e_exc = e_exc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    jal_id         = v.jal;
    jalr_id        = v.jalr;
    pc_id          = v.pc;
    imm_id         = v.imm;
    rs1_data_id    = v.rs1;
    rs1_ready      = v.rs1_rdy;
    redirect_ready = v.rdy;
  endtask

  task automatic checkAll(input string tag, input logic e_valid,
                          input logic [31:0] e_pc, input logic e_flush,
                          input logic e_stall, input logic e_lwe,
                          input logic [31:0] e_link, input logic e_exc);
    checkOutput({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e_valid));
    checkOutput({tag, ".redirect_pc"},    redirect_pc,         e_pc);
    checkOutput({tag, ".flush_ir"},       32'(flush_ir),       32'(e_flush));
    checkOutput({tag, ".stall_if"},       32'(stall_if),       32'(e_stall));
    checkOutput({tag, ".link_we"},        32'(link_we),        32'(e_lwe));
    checkOutput({tag, ".link_data"},      link_data,           e_link);
    checkOutput({tag, ".misalign_exc"},   32'(misalign_exc),   32'(e_exc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                jal jalr pc            imm      rs1           r1 rdy | vld pc         fl st lwe link      exc
    // JAL, no backpressure; a JAL during FLUSH is ignored
    vecs[0]  = mkv(1, 0, 32'h100,      32'h20, 32'h0,        0, 1,  1, 32'h120,  1, 1, 1, 32'h104, 0);
    vecs[1]  = mkv(0, 0, 32'h100,      32'h20, 32'h0,        0, 1,  0, 32'h120,  1, 0, 0, 32'h104, 0);
    vecs[2]  = mkv(1, 0, 32'h200,      32'h8,  32'h0,        0, 1,  0, 32'h120,  0, 0, 0, 32'h104, 0);
    vecs[3]  = mkv(0, 0, 32'h200,      32'h8,  32'h0,        0, 0,  0, 32'h120,  0, 0, 0, 32'h104, 0);
    // JALR waiting on rs1 for three cycles, misaligned target 0x2006
    vecs[4]  = mkv(0, 1, 32'h300,      32'h4,  32'h0,        0, 0,  0, 32'h120,  0, 1, 0, 32'h304, 0);
    vecs[5]  = mkv(0, 1, 32'h300,      32'h4,  32'h0,        0, 0,  0, 32'h120,  0, 1, 0, 32'h304, 0);
    vecs[6]  = mkv(0, 1, 32'h300,      32'h4,  32'h0,        0, 0,  0, 32'h120,  0, 1, 0, 32'h304, 0);
    vecs[7]  = mkv(0, 1, 32'h300,      32'h4,  32'h2003,     1, 0,  0, 32'h2006, 1, 0, 0, 32'h304, 1);
    vecs[8]  = mkv(0, 0, 32'h300,      32'h4,  32'h2003,     0, 0,  0, 32'h2006, 0, 0, 0, 32'h304, 0);
    // JALR waiting on rs1, aligned target 0x2004 from held imm (live imm differs)
    vecs[9]  = mkv(0, 1, 32'h400,      32'h4,  32'h0,        0, 0,  0, 32'h2006, 0, 1, 0, 32'h404, 0);
    vecs[10] = mkv(0, 1, 32'h400,      32'h40, 32'h2001,     1, 1,  1, 32'h2004, 1, 1, 1, 32'h404, 0);
    // Backpressure for four cycles; flags and rs1_ready ignored in REDIRECT
    vecs[11] = mkv(0, 0, 32'h400,      32'h40, 32'h2001,     0, 0,  1, 32'h2004, 1, 1, 0, 32'h404, 0);
    vecs[12] = mkv(1, 0, 32'h800,      32'h40, 32'h2001,     1, 0,  1, 32'h2004, 1, 1, 0, 32'h404, 0);
    vecs[13] = mkv(0, 1, 32'h800,      32'h40, 32'h2001,     0, 0,  1, 32'h2004, 1, 1, 0, 32'h404, 0);
    vecs[14] = mkv(0, 0, 32'h800,      32'h40, 32'h2001,     1, 0,  1, 32'h2004, 1, 1, 0, 32'h404, 0);
    vecs[15] = mkv(0, 0, 32'h800,      32'h40, 32'h2001,     0, 1,  0, 32'h2004, 1, 0, 0, 32'h404, 0);
    vecs[16] = mkv(0, 0, 32'h800,      32'h40, 32'h2001,     0, 0,  0, 32'h2004, 0, 0, 0, 32'h404, 0);
    // Both flags high: JALR wins, rs1+imm wraps to 0x8
    vecs[17] = mkv(1, 1, 32'h500,      32'h10, 32'hFFFFFFF8, 1, 0,  1, 32'h8,    1, 1, 1, 32'h504, 0);
    vecs[18] = mkv(0, 0, 32'h500,      32'h10, 32'hFFFFFFF8, 1, 1,  0, 32'h8,    1, 0, 0, 32'h504, 0);
    vecs[19] = mkv(0, 0, 32'h500,      32'h10, 32'hFFFFFFF8, 1, 0,  0, 32'h8,    0, 0, 0, 32'h504, 0);
    // JAL with PC wrap: target 0x4, link wraps to 0
    vecs[20] = mkv(1, 0, 32'hFFFFFFFC, 32'h8,  32'h0,        0, 0,  1, 32'h4,    1, 1, 1, 32'h0,   0);
    vecs[21] = mkv(0, 0, 32'hFFFFFFFC, 32'h8,  32'h0,        0, 1,  0, 32'h4,    1, 0, 0, 32'h0,   0);
    vecs[22] = mkv(0, 0, 32'hFFFFFFFC, 32'h8,  32'h0,        0, 0,  0, 32'h4,    0, 0, 0, 32'h0,   0);
    // JAL with misaligned target 0x102
    vecs[23] = mkv(1, 0, 32'h100,      32'h2,  32'h0,        0, 0,  0, 32'h102,  1, 0, 0, 32'h104, 1);
    vecs[24] = mkv(0, 0, 32'h100,      32'h2,  32'h0,        0, 0,  0, 32'h102,  0, 0, 0, 32'h104, 0);

    rst_n = 1'b0;
    applyStimulus(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    checkAll("reset", 0, 32'h0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
               vecs[i].e_flush, vecs[i].e_stall, vecs[i].e_lwe,
               vecs[i].e_link, vecs[i].e_exc);
    end

    // Asynchronous reset while a redirect is being back-pressured
    applyStimulus(mkv(1, 0, 32'h600, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkAll("pre_rst", 1, 32'h610, 1, 1, 1, 32'h604, 0);
    applyStimulus(mkv(0, 0, 32'h600, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 0, 32'h0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkv(1, 0, 32'h40, 32'h10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkAll("post_rst_jal", 1, 32'h50, 1, 1, 1, 32'h44, 0);
    applyStimulus(mkv(0, 0, 32'h40, 32'h10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkAll("post_rst_flush", 0, 32'h50, 1, 0, 0, 32'h44, 0);
    tick();
    checkAll("post_rst_idle", 0, 32'h50, 0, 0, 0, 32'h44, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
